// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: carries decoded fields into EX, inserts bubbles
// on load-use stalls, clears on flush, and counts inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W    = 32,
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
  input  logic                 flush,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic [DATA_W-1:0]    id_inst,
  input  logic [REGADDR_W-1:0] id_wd,
  input  logic                 id_wreg,
  input  logic                 id_is_in_delayslot,
  input  logic                 next_inst_in_delayslot,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic [DATA_W-1:0]    ex_inst,
  output logic [REGADDR_W-1:0] ex_wd,
  output logic                 ex_wreg,
  output logic                 ex_is_in_delayslot,
  output logic                 is_in_delayslot_o,
  output logic                 ex_valid,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic id_stall;
  logic ex_stall;
  logic bubble;
  logic load_nop;
  logic unused_stall;

  assign id_stall     = stall[2];
  assign ex_stall     = stall[3];
  // ID stalled while EX keeps running: EX must see a NOP, not a duplicate.
  assign bubble       = id_stall & ~ex_stall;
  assign load_nop     = flush | bubble;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of its neighbours; blocking would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_aluop           <= '0;
      ex_alusel          <= '0;
      ex_reg1            <= '0;
      ex_reg2            <= '0;
      ex_inst            <= '0;
      ex_wd              <= '0;
      ex_wreg            <= 1'b0;
      ex_is_in_delayslot <= 1'b0;
      is_in_delayslot_o  <= 1'b0;
      ex_valid           <= 1'b0;
      bubble_cnt         <= '0;
    end else if (load_nop) begin
      ex_aluop           <= '0;
      ex_alusel          <= '0;
      ex_reg1            <= '0;
      ex_reg2            <= '0;
      ex_inst            <= '0;
      ex_wd              <= '0;
      ex_wreg            <= 1'b0;
      ex_is_in_delayslot <= 1'b0;
      ex_valid           <= 1'b0;
      // Flush discards the pending delay-slot marker; a bubble keeps it
      // because the branch's slot instruction is still waiting in ID.
      if (flush) begin
        is_in_delayslot_o <= 1'b0;
      end else if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else if (!ex_stall) begin
      ex_aluop           <= id_aluop;
      ex_alusel          <= id_alusel;
      ex_reg1            <= id_reg1;
      ex_reg2            <= id_reg2;
      ex_inst            <= id_inst;
      ex_wd              <= id_wd;
      ex_wreg            <= id_wreg;
      ex_is_in_delayslot <= id_is_in_delayslot;
      is_in_delayslot_o  <= next_inst_in_delayslot;
      ex_valid           <= 1'b1;
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and instruction width.
REQ-002 Parameter ALUOP_W, default 8, ALU operation code width; ALUSEL_W, default 3, result-select width; REGADDR_W, default 5, register address width.
REQ-003 Parameter CNT_W, default 16, bubble-counter width.
REQ-004 clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 stall  in  6  pipeline stall vector; bit 2 = ID stalled, bit 3 = EX stalled.
REQ-006 flush  in  1  discard stage contents (exception/redirect).
REQ-007 id_aluop  in  ALUOP_W; id_alusel  in  ALUSEL_W; id_reg1, id_reg2, id_inst  in  DATA_W; id_wd  in  REGADDR_W; id_wreg  in  1  decoded instruction fields.
REQ-008 id_is_in_delayslot  in  1  current ID instruction occupies a delay slot; next_inst_in_delayslot  in  1  ID has decoded a branch.
REQ-009 ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_inst, ex_wd, ex_wreg  out  widths as REQ-007  registered fields to EX.
REQ-010 ex_is_in_delayslot  out  1; is_in_delayslot_o  out  1  delay-slot flag returned to ID for the next instruction.
REQ-011 ex_valid  out  1  EX holds a real instruction (not bubble).
REQ-012 bubble_cnt  out  CNT_W  count of bubbles inserted since reset.

Function
REQ-013 All state SHALL update only on rising clk; no combinational path from any input to any output.
REQ-014 Priority per cycle SHALL be: rst > flush > bubble insert > hold > advance.
REQ-015 Flush: all ex_* fields SHALL load NOP values (aluop 0, alusel 0, reg1/reg2/inst 0, wd 0, wreg 0, delay-slot 0), ex_valid 0, is_in_delayslot_o 0; bubble_cnt unchanged.
REQ-016 Bubble insert (stall[2]=1 and stall[3]=0): ex_* SHALL load NOP values, ex_valid 0, is_in_delayslot_o held, bubble_cnt incremented by 1.
REQ-017 Hold (stall[3]=1): all registered outputs SHALL keep their values, including is_in_delayslot_o and bubble_cnt.
REQ-018 Advance (stall[2]=0, stall[3]=0): ex_* SHALL load the corresponding id_* inputs, ex_is_in_delayslot loads id_is_in_delayslot, is_in_delayslot_o loads next_inst_in_delayslot, ex_valid loads 1.
REQ-019 Latency SHALL be exactly one cycle from ID input to EX output on advance.
REQ-020 bubble_cnt SHALL saturate at all-ones; no wrap to zero.
REQ-021 stall[2]=0 with stall[3]=1 is illegal upstream; the block SHALL treat it as hold.
REQ-022 Flush asserted together with any stall SHALL still clear the stage (flush wins over hold).
REQ-023 All widths SHALL follow the parameters; no hard-coded 32/8/5/3 constants.

Reset
REQ-024 With rst=1 at a rising edge, all ex_* fields SHALL take NOP values, ex_valid 0, is_in_delayslot_o 0, bubble_cnt 0, regardless of stall/flush.
REQ-025 Reset asserted mid-hold or mid-bubble SHALL override it; first edge after rst deasserts behaves per REQ-014.

Verification
REQ-026 Advance: id_aluop=0x25, id_reg1=0x1234, id_wd=3, id_wreg=1, stall=0 -> next cycle ex_aluop=0x25, ex_reg1=0x1234, ex_wd=3, ex_wreg=1, ex_valid=1.
REQ-027 Load-use bubble: stall=6'b000111 for 2 cycles -> ex_wreg=0, ex_valid=0 both cycles, bubble_cnt=2.
REQ-028 Hold: stall=6'b001111 for 3 cycles while id_* change -> ex_* unchanged, bubble_cnt unchanged.
REQ-029 Delay slot: next_inst_in_delayslot=1 on advance -> is_in_delayslot_o=1; ID drives id_is_in_delayslot=1 next advance -> ex_is_in_delayslot=1.
REQ-030 Flush with stall=6'b001111 -> next cycle all ex_* NOP, ex_valid=0, is_in_delayslot_o=0.
REQ-031 Saturation with CNT_W=4: 20 bubble cycles -> bubble_cnt=15; rst=1 one cycle -> bubble_cnt=0, all outputs NOP.
